bias_loader: RTL and testbench

- Fetches one tile's bias vector from memory and writes it row by row into the bias adder's write port.
- Drives the adder's `init_bias_cfg` / `valid_row_num` / `need_bias` configuration pulse.
- Tracks the adder's two bias buffers with a credit counter, so it never overwrites a buffer still being consumed.
- Sits between the layer sequencer (start command) and the memory read port on one side, and the bias adder on the other.

---
 rtl/bias_pkg.sv | 47 ++++
 rtl/bias_credit_ctr.sv | 35 +++
 rtl/bias_loader.sv | 208 ++++++++++++++++++++
 tb/tb_bias_loader.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_pkg.sv
// Shared types and constants for the bias loader and its credit counter.
package bias_pkg;

  // Loader control states.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_CFG         = 3'd1,
    ST_WAIT_CREDIT = 3'd2,
    ST_FETCH       = 3'd3,
    ST_FINISH      = 3'd4
  } bias_ld_state_e;

  // The adder double-buffers its bias, so at most two tiles may be loaded ahead.
  localparam int unsigned NUM_BIAS_BUF   = 2;
  localparam int unsigned BIAS_BUS_WIDTH = 32;
  localparam int unsigned BIAS_ROW_BYTES = BIAS_BUS_WIDTH / 8;
  localparam int unsigned CREDIT_W       = $clog2(NUM_BIAS_BUF + 1);

  // Byte stride between consecutive bias rows for a given bus width.
  function automatic int unsigned bias_row_bytes(input int unsigned bus_width);
    return bus_width / 8;
  endfunction

  // Credit update: consume and release in the same cycle cancel out, a
  // release at the maximum is dropped, a consume at zero is ignored.
  function automatic logic [CREDIT_W-1:0] credit_next(
    input logic [CREDIT_W-1:0] cnt,
    input logic                take,
    input logic                give
  );
    logic [CREDIT_W-1:0] nxt;
    nxt = cnt;
    case ({take, give})
      2'b10: begin
        if (cnt != CREDIT_W'(0)) nxt = cnt - CREDIT_W'(1);
        else                     nxt = cnt;
      end
      2'b01: begin
        if (cnt < CREDIT_W'(NUM_BIAS_BUF)) nxt = cnt + CREDIT_W'(1);
        else                               nxt = cnt;
      end
      default: nxt = cnt;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bias_credit_ctr.sv
// Tracks how many of the adder's bias buffers are free to be filled.
module bias_credit_ctr
  import bias_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                consume_i,
  input  logic                release_i,
  output logic                avail_o,
  output logic [CREDIT_W-1:0] count_o
);

  logic [CREDIT_W-1:0] count_q;
  logic [CREDIT_W-1:0] count_d;

  // Next credit count from this cycle's consume/release events.
  always_comb begin
    count_d = credit_next(count_q, consume_i, release_i);
  end

  // Credit register; both buffers are free out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= CREDIT_W'(NUM_BIAS_BUF);
    end else begin
      count_q <= count_d;
    end
  end

  // A release arriving this cycle already frees a buffer, so a waiting
  // load may take it immediately without losing a cycle.
  assign avail_o = (count_q != CREDIT_W'(0)) || release_i;
  assign count_o = count_q;

endmodule

// File: rtl/bias_loader.sv
// Fetches one tile's bias rows from memory and writes them into the bias
// adder, gated by a credit count of free adder bias buffers.
module bias_loader
  import bias_pkg::*;
#(
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [ADDR_WIDTH-1:0]    base_addr_i,
  input  logic [$clog2(SIZE)-1:0]  row_num_i,
  input  logic                     need_bias_i,
  output logic                     rd_req_valid_o,
  input  logic                     rd_req_ready_i,
  output logic [ADDR_WIDTH-1:0]    rd_req_addr_o,
  input  logic                     rd_rsp_valid_i,
  input  logic [BUS_WIDTH-1:0]     rd_rsp_data_i,
  output logic                     init_bias_cfg_o,
  output logic [$clog2(SIZE)-1:0]  valid_row_num_o,
  output logic                     need_bias_o,
  output logic                     bias_wr_en_o,
  output logic [$clog2(SIZE)-1:0]  bias_wr_addr_o,
  output logic [BUS_WIDTH-1:0]     bias_data_o,
  input  logic                     bias_loading_done_i,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int RW = $clog2(SIZE);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(bias_row_bytes(BUS_WIDTH));

  bias_ld_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [RW-1:0]         row_num_q, row_num_d;
  logic                  need_bias_q, need_bias_d;
  logic                  req_valid_q, req_valid_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [RW-1:0]         req_cnt_q, req_cnt_d;
  logic [RW-1:0]         rsp_cnt_q, rsp_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [RW-1:0]         wr_addr_q, wr_addr_d;
  logic [BUS_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                  cfg_q, cfg_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  consume_s;
  logic                  avail_s;
  logic                  req_fire_s;
  logic                  rsp_fire_s;
  logic                  last_wr_s;
  logic [CREDIT_W-1:0]   credit_cnt_s;

  bias_credit_ctr u_credit (
    .clk       (clk),
    .rst       (rst),
    .consume_i (consume_s),
    .release_i (bias_loading_done_i),
    .avail_o   (avail_s),
    .count_o   (credit_cnt_s)
  );

  assign req_fire_s = req_valid_q && rd_req_ready_i;
  // Beats outside FETCH belong to no active load and are dropped.
  assign rsp_fire_s = (state_q == ST_FETCH) && rd_rsp_valid_i;
  // The final row has been presented to the adder this cycle.
  assign last_wr_s  = wr_en_q && (wr_addr_q == row_num_q);

  // Control FSM; a credit is taken exactly on the transition into FETCH.
  always_comb begin
    state_d   = state_q;
    consume_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_CFG;
        else         state_d = ST_IDLE;
      end
      ST_CFG: begin
        if (!need_bias_q) begin
          state_d = ST_FINISH;
        end else if (avail_s) begin
          consume_s = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          state_d = ST_WAIT_CREDIT;
        end
      end
      ST_WAIT_CREDIT: begin
        if (avail_s) begin
          consume_s = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          state_d = ST_WAIT_CREDIT;
        end
      end
      ST_FETCH: begin
        if (last_wr_s) state_d = ST_FINISH;
        else           state_d = ST_FETCH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Command latch, request issue and response-to-write datapath.
  always_comb begin
    base_d      = base_q;
    row_num_d   = row_num_q;
    need_bias_d = need_bias_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_cnt_d   = req_cnt_q;
    rsp_cnt_d   = rsp_cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if ((state_q == ST_IDLE) && start_i) begin
      base_d      = base_addr_i;
      row_num_d   = row_num_i;
      need_bias_d = need_bias_i;
    end else begin
      base_d      = base_q;
    end

    // Address advances only on acceptance, so it holds while stalled.
    if (consume_s) begin
      req_valid_d = 1'b1;
      req_addr_d  = base_q;
      req_cnt_d   = {RW{1'b0}};
      rsp_cnt_d   = {RW{1'b0}};
    end else if (req_fire_s) begin
      req_cnt_d = req_cnt_q + RW'(1);
      if (req_cnt_q == row_num_q) req_valid_d = 1'b0;
      else                        req_addr_d  = req_addr_q + ROW_STEP;
    end else begin
      req_valid_d = req_valid_q;
    end

    if (rsp_fire_s) begin
      wr_en_d   = 1'b1;
      wr_addr_d = rsp_cnt_q;
      wr_data_d = rd_rsp_data_i;
      rsp_cnt_d = rsp_cnt_q + RW'(1);
    end else begin
      wr_en_d = 1'b0;
    end
  end

  // Status pulses follow the upcoming state so they line up with it.
  always_comb begin
    cfg_d  = (state_d == ST_CFG);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FINISH);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= {ADDR_WIDTH{1'b0}};
      row_num_q   <= {RW{1'b0}};
      need_bias_q <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= {ADDR_WIDTH{1'b0}};
      req_cnt_q   <= {RW{1'b0}};
      rsp_cnt_q   <= {RW{1'b0}};
      wr_en_q     <= 1'b0;
      wr_addr_q   <= {RW{1'b0}};
      wr_data_q   <= {BUS_WIDTH{1'b0}};
      cfg_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      row_num_q   <= row_num_d;
      need_bias_q <= need_bias_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_cnt_q   <= req_cnt_d;
      rsp_cnt_q   <= rsp_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cfg_q       <= cfg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_req_valid_o  = req_valid_q;
  assign rd_req_addr_o   = req_addr_q;
  assign init_bias_cfg_o = cfg_q;
  assign valid_row_num_o = row_num_q;
  assign need_bias_o     = need_bias_q;
  assign bias_wr_en_o    = wr_en_q;
  assign bias_wr_addr_o  = wr_addr_q;
  assign bias_data_o     = wr_data_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_bias_loader.sv
// Directed bench for bias_loader with a small in-order memory model.
module tb_bias_loader;

  localparam logic [31:0] KEY = 32'hB1A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = 32'd0;
  logic [3:0]  row_num_i = 4'd0;
  logic        need_bias_i = 1'b0;
  logic        rd_req_valid_o;
  logic        rd_req_ready_i = 1'b1;
  logic [31:0] rd_req_addr_o;
  logic        rd_rsp_valid_i = 1'b0;
  logic [31:0] rd_rsp_data_i = 32'd0;
  logic        init_bias_cfg_o;
  logic [3:0]  valid_row_num_o;
  logic        need_bias_o;
  logic        bias_wr_en_o;
  logic [3:0]  bias_wr_addr_o;
  logic [31:0] bias_data_o;
  logic        bias_loading_done_i = 1'b0;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int mem_lat = 1;
  bit rnd_ready = 1'b0;
  int start_cyc, done_cyc, cfg_cyc, first_req_cyc, stall_viol;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] req_log[$];
  logic [3:0]  wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'd0;

  bias_loader dut (
    .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
    .row_num_i(row_num_i), .need_bias_i(need_bias_i),
    .rd_req_valid_o(rd_req_valid_o), .rd_req_ready_i(rd_req_ready_i),
    .rd_req_addr_o(rd_req_addr_o), .rd_rsp_valid_i(rd_rsp_valid_i),
    .rd_rsp_data_i(rd_rsp_data_i), .init_bias_cfg_o(init_bias_cfg_o),
    .valid_row_num_o(valid_row_num_o), .need_bias_o(need_bias_o),
    .bias_wr_en_o(bias_wr_en_o), .bias_wr_addr_o(bias_wr_addr_o),
    .bias_data_o(bias_data_o), .bias_loading_done_i(bias_loading_done_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // Memory: drives ready and returns one beat per accepted request, in order,
  // in cycle accept+1+mem_lat; data is the address xor KEY.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rnd_ready) rd_req_ready_i = ($urandom_range(0, 1) == 1);
    else           rd_req_ready_i = 1'b1;
    if (mq_due.size() > 0 && mq_due[0] == cyc) begin
      rd_rsp_valid_i = 1'b1;
      rd_rsp_data_i  = mq_addr[0] ^ KEY;
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      rd_rsp_valid_i = 1'b0;
      rd_rsp_data_i  = 32'd0;
    end
  end

  // Monitor: logs handshakes, writes and pulses mid-cycle; counts stalled-address changes.
  always @(negedge clk) begin
    if (rd_req_valid_o && rd_req_ready_i) begin
      mq_addr.push_back(rd_req_addr_o);
      mq_due.push_back(cyc + mem_lat + 1);
      req_log.push_back(rd_req_addr_o);
    end
    if (bias_wr_en_o) begin
      wr_addr_log.push_back(bias_wr_addr_o);
      wr_data_log.push_back(bias_data_o);
    end
    if (done_o) done_cyc = cyc;
    if (init_bias_cfg_o) cfg_cyc = cyc;
    if (rd_req_valid_o && first_req_cyc < 0) first_req_cyc = cyc;
    if (prev_stall && !(rd_req_valid_o && rd_req_addr_o == prev_addr)) stall_viol++;
    prev_stall = rd_req_valid_o && !rd_req_ready_i && !rst;
    prev_addr  = rd_req_addr_o;
  end

  task automatic clear_logs();
    req_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    done_cyc = -1;
    cfg_cyc = -1;
    first_req_cyc = -1;
    stall_viol = 0;
  endtask

  task automatic do_start(input logic [31:0] base, input logic [3:0] rn, input logic nb);
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = base; row_num_i = rn; need_bias_i = nb;
    start_cyc = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic give_credit();
    @(posedge clk); #1; bias_loading_done_i = 1'b1;
    @(posedge clk); #1; bias_loading_done_i = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done_o) begin seen = 1'b1; break; end
    end
    #1;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: got no done_o, expected done_o within %0d cycles", tag, max_cyc);
    end
  endtask

  task automatic test_reset();
    logic [77:0] outs;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    outs = {rd_req_valid_o, rd_req_addr_o, init_bias_cfg_o, valid_row_num_o, need_bias_o,
            bias_wr_en_o, bias_wr_addr_o, bias_data_o, busy_o, done_o};
    n_checks++;
    if (outs !== 78'd0) begin n_fail++; $display("FAIL reset_outputs: got %0h, expected 0", outs); end
    n_checks++;
    if (dut.u_credit.count_o !== 2'd2) begin n_fail++; $display("FAIL reset_credits: got %0d, expected 2", dut.u_credit.count_o); end
  endtask

  task automatic test_basic();
    logic [31:0] ea;
    clear_logs(); mem_lat = 1; rnd_ready = 1'b0;
    do_start(32'h0000_1000, 4'd3, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({init_bias_cfg_o, valid_row_num_o, need_bias_o} !== {1'b1, 4'd3, 1'b1}) begin
      n_fail++; $display("FAIL basic_cfg: got %b, expected 1_0011_1", {init_bias_cfg_o, valid_row_num_o, need_bias_o});
    end
    wait_done(40, "basic");
    n_checks++;
    if (first_req_cyc - start_cyc !== 2) begin n_fail++; $display("FAIL basic_first_req: got cycle %0d, expected 2", first_req_cyc - start_cyc); end
    n_checks++;
    if (done_cyc - start_cyc !== 9) begin n_fail++; $display("FAIL basic_done_cycle: got %0d, expected 9", done_cyc - start_cyc); end
    n_checks++;
    if (req_log.size() !== 4 || wr_addr_log.size() !== 4) begin
      n_fail++; $display("FAIL basic_counts: got %0d req %0d wr, expected 4 and 4", req_log.size(), wr_addr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        ea = 32'h0000_1000 + 32'(4 * i);
        n_checks++;
        if (req_log[i] !== ea || wr_addr_log[i] !== 4'(i) || wr_data_log[i] !== (ea ^ KEY)) begin
          n_fail++; $display("FAIL basic_row%0d: got req %0h wr %0d data %0h, expected %0h %0d %0h",
                             i, req_log[i], wr_addr_log[i], wr_data_log[i], ea, i, ea ^ KEY);
        end
      end
    end
    n_checks++;
    if (dut.u_credit.count_o !== 2'd1) begin n_fail++; $display("FAIL basic_credits: got %0d, expected 1", dut.u_credit.count_o); end
    give_credit();
  endtask

  task automatic test_no_bias();
    clear_logs(); mem_lat = 1; rnd_ready = 1'b0;
    do_start(32'h0000_2000, 4'd5, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({init_bias_cfg_o, valid_row_num_o, need_bias_o} !== {1'b1, 4'd5, 1'b0}) begin
      n_fail++; $display("FAIL nobias_cfg: got %b, expected 1_0101_0", {init_bias_cfg_o, valid_row_num_o, need_bias_o});
    end
    wait_done(10, "nobias");
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_cyc - start_cyc !== 2) begin n_fail++; $display("FAIL nobias_done_cycle: got %0d, expected 2", done_cyc - start_cyc); end
    n_checks++;
    if (req_log.size() !== 0 || wr_addr_log.size() !== 0 || first_req_cyc !== -1) begin
      n_fail++; $display("FAIL nobias_traffic: got %0d req %0d wr, expected 0 and 0", req_log.size(), wr_addr_log.size());
    end
    n_checks++;
    if (dut.u_credit.count_o !== 2'd2) begin n_fail++; $display("FAIL nobias_credits: got %0d, expected 2", dut.u_credit.count_o); end
  endtask

  task automatic test_credit_stall();
    int rel_cyc;
    clear_logs(); mem_lat = 1; rnd_ready = 1'b0;
    do_start(32'h0000_4000, 4'd1, 1'b1); wait_done(40, "stall_a");
    do_start(32'h0000_5000, 4'd1, 1'b1); wait_done(40, "stall_b");
    n_checks++;
    if (dut.u_credit.count_o !== 2'd0) begin n_fail++; $display("FAIL stall_credits_empty: got %0d, expected 0", dut.u_credit.count_o); end
    clear_logs();
    do_start(32'h0000_6000, 4'd1, 1'b1);
    repeat (8) @(negedge clk);
    n_checks++;
    if (first_req_cyc !== -1 || busy_o !== 1'b1 || done_cyc !== -1) begin
      n_fail++; $display("FAIL stall_wait: got first_req %0d busy %b, expected -1 and 1", first_req_cyc, busy_o);
    end
    @(posedge clk); #1; bias_loading_done_i = 1'b1; rel_cyc = cyc;
    @(posedge clk); #1; bias_loading_done_i = 1'b0;
    wait_done(40, "stall_c");
    n_checks++;
    if (first_req_cyc !== rel_cyc + 1) begin n_fail++; $display("FAIL stall_resume: got req cycle %0d, expected %0d", first_req_cyc, rel_cyc + 1); end
    n_checks++;
    if (wr_addr_log.size() !== 2 || dut.u_credit.count_o !== 2'd0) begin
      n_fail++; $display("FAIL stall_after: got %0d writes credits %0d, expected 2 and 0", wr_addr_log.size(), dut.u_credit.count_o);
    end
    give_credit(); give_credit();
  endtask

  task automatic test_simul_credit();
    clear_logs(); mem_lat = 1; rnd_ready = 1'b0;
    do_start(32'h0000_7000, 4'd0, 1'b1); wait_done(40, "simul_a");
    clear_logs();
    do_start(32'h0000_7100, 4'd0, 1'b1);
    bias_loading_done_i = 1'b1;
    @(posedge clk); #1; bias_loading_done_i = 1'b0;
    wait_done(40, "simul_b");
    n_checks++;
    if (dut.u_credit.count_o !== 2'd1 || first_req_cyc - start_cyc !== 2) begin
      n_fail++; $display("FAIL simul_same_cycle: got credits %0d req cycle %0d, expected 1 and 2",
                         dut.u_credit.count_o, first_req_cyc - start_cyc);
    end
    give_credit(); give_credit();
    n_checks++;
    if (dut.u_credit.count_o !== 2'd2) begin n_fail++; $display("FAIL simul_saturate: got %0d, expected 2", dut.u_credit.count_o); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ea;
    clear_logs(); mem_lat = 4; rnd_ready = 1'b1;
    do_start(32'hFFFF_FFF0, 4'd7, 1'b1);
    wait_done(200, "bp");
    rnd_ready = 1'b0;
    n_checks++;
    if (stall_viol !== 0) begin n_fail++; $display("FAIL bp_addr_stable: got %0d changes, expected 0", stall_viol); end
    n_checks++;
    if (req_log.size() !== 8 || wr_addr_log.size() !== 8) begin
      n_fail++; $display("FAIL bp_counts: got %0d req %0d wr, expected 8 and 8", req_log.size(), wr_addr_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        ea = 32'hFFFF_FFF0 + 32'(4 * i);
        n_checks++;
        if (req_log[i] !== ea || wr_addr_log[i] !== 4'(i) || wr_data_log[i] !== (ea ^ KEY)) begin
          n_fail++; $display("FAIL bp_row%0d: got req %0h wr %0d data %0h, expected %0h %0d %0h",
                             i, req_log[i], wr_addr_log[i], wr_data_log[i], ea, i, ea ^ KEY);
        end
      end
    end
    give_credit();
  endtask

  task automatic test_reset_mid();
    logic [77:0] outs;
    logic [31:0] ea;
    clear_logs(); mem_lat = 4; rnd_ready = 1'b0;
    do_start(32'h0000_2000, 4'd7, 1'b1);
    for (int i = 0; i < 40 && wr_addr_log.size() < 2; i++) begin @(negedge clk); #1; end
    n_checks++;
    if (wr_addr_log.size() < 2) begin n_fail++; $display("FAIL rstmid_progress: got %0d writes, expected 2", wr_addr_log.size()); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    outs = {rd_req_valid_o, rd_req_addr_o, init_bias_cfg_o, valid_row_num_o, need_bias_o,
            bias_wr_en_o, bias_wr_addr_o, bias_data_o, busy_o, done_o};
    n_checks++;
    if (outs !== 78'd0 || dut.u_credit.count_o !== 2'd2) begin
      n_fail++; $display("FAIL rstmid_outputs: got %0h credits %0d, expected 0 and 2", outs, dut.u_credit.count_o);
    end
    #1; clear_logs();
    repeat (12) @(negedge clk);
    #1;
    n_checks++;
    if (wr_addr_log.size() !== 0 || req_log.size() !== 0 || done_cyc !== -1) begin
      n_fail++; $display("FAIL rstmid_dropped: got %0d writes %0d req, expected 0 and 0", wr_addr_log.size(), req_log.size());
    end
    clear_logs();
    do_start(32'h0000_3000, 4'd2, 1'b1);
    wait_done(60, "rstmid_new");
    n_checks++;
    if (done_cyc - start_cyc !== 11 || wr_addr_log.size() !== 3) begin
      n_fail++; $display("FAIL rstmid_new_load: got done %0d writes %0d, expected 11 and 3", done_cyc - start_cyc, wr_addr_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        ea = 32'h0000_3000 + 32'(4 * i);
        n_checks++;
        if (wr_addr_log[i] !== 4'(i) || wr_data_log[i] !== (ea ^ KEY)) begin
          n_fail++; $display("FAIL rstmid_row%0d: got wr %0d data %0h, expected %0d %0h", i, wr_addr_log[i], wr_data_log[i], i, ea ^ KEY);
        end
      end
    end
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_basic();
    test_no_bias();
    test_credit_stall();
    test_simul_credit();
    test_backpressure();
    test_reset_mid();
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
